// File: rtl/regfile_write_arbiter_if.sv
// Bundle between the result producers / decode stage and the register-file
// write arbiter: two valid/ready result channels, the long-latency issue
// notification, decode source operands with the hazard stall, and the
// register file write port.
interface regfile_write_arbiter_if;
    // ALU writeback channel
    logic        aluValid;
    logic [4:0]  aluAddress;
    logic [31:0] aluData;
    logic        aluReady;
    // memory / multiply result channel
    logic        memValid;
    logic [4:0]  memAddress;
    logic [31:0] memData;
    logic        memReady;
    // long-latency issue and decode hazard query
    logic        issueValid;
    logic [4:0]  issueAddress;
    logic [4:0]  rsAddress;
    logic [4:0]  rtAddress;
    logic        stall;
    // register file write port
    logic        registerWrite;
    logic [4:0]  writeAddress;
    logic [31:0] writeData;

    // Producer / decode side
    modport master (
        output aluValid, aluAddress, aluData,
        output memValid, memAddress, memData,
        output issueValid, issueAddress, rsAddress, rtAddress,
        input  aluReady, memReady, stall,
        input  registerWrite, writeAddress, writeData
    );

    // Arbiter side
    modport slave (
        input  aluValid, aluAddress, aluData,
        input  memValid, memAddress, memData,
        input  issueValid, issueAddress, rsAddress, rtAddress,
        output aluReady, memReady, stall,
        output registerWrite, writeAddress, writeData
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Register file write-port arbiter. ALU results normally win the single write
// port; the memory/multiply unit wins a conflict once it has lost MAX_STARVE
// conflicts in a row. A pending-write scoreboard tracks destinations owed by
// issued long-latency ops so decode can stall on RAW/WAW hazards.
module regfile_write_arbiter #(
    parameter int MAX_STARVE = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    regfile_write_arbiter_if.slave  bus
);

    localparam logic [3:0] STARVE_LIMIT = 4'(MAX_STARVE);

    logic [3:0]  starve_count_reg;
    logic [3:0]  starve_count_next;
    logic [31:0] pending_reg;
    logic [31:0] pending_next;
    logic        register_write_reg;
    logic [4:0]  write_address_reg;
    logic [31:0] write_data_reg;

    logic        mem_priority;
    logic        alu_grant;
    logic        mem_grant;
    logic        any_grant;
    logic [4:0]  grant_address;
    logic [31:0] grant_data;

    // Pick the winner of the write port; nothing is accepted while in reset so
    // held results are taken only after reset is released.
    always_comb begin
        mem_priority  = (starve_count_reg == STARVE_LIMIT);
        alu_grant     = rst && bus.aluValid && (!bus.memValid || !mem_priority);
        mem_grant     = rst && bus.memValid && (!bus.aluValid || mem_priority);
        any_grant     = alu_grant || mem_grant;
        grant_address = mem_grant ? bus.memAddress : bus.aluAddress;
        grant_data    = mem_grant ? bus.memData    : bus.aluData;
    end

    // Count consecutive conflicts lost by mem; any other outcome restarts it.
    always_comb begin
        starve_count_next = 4'd0;
        if (bus.aluValid && bus.memValid && alu_grant) begin
            starve_count_next = (starve_count_reg == STARVE_LIMIT) ?
                                starve_count_reg : starve_count_reg + 4'd1;
        end
    end

    // Scoreboard update per register: an issue sets, a mem grant clears, and a
    // set in the same cycle as a clear wins. r0 is never owed.
    assign pending_next[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_pending
            logic set_bit;
            logic clear_bit;
            assign set_bit   = bus.issueValid && (bus.issueAddress == 5'(gi));
            assign clear_bit = mem_grant && (bus.memAddress == 5'(gi));
            assign pending_next[gi] = set_bit || (pending_reg[gi] && !clear_bit);
        end
    endgenerate

    // Scoreboard and starvation state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_count_reg <= 4'd0;
            pending_reg      <= 32'd0;
        end else begin
            starve_count_reg <= starve_count_next;
            pending_reg      <= pending_next;
        end
    end

    // Registered write port; writes to r0 are accepted but never enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            register_write_reg <= 1'b0;
            write_address_reg  <= 5'd0;
            write_data_reg     <= 32'd0;
        end else begin
            register_write_reg <= any_grant && (grant_address != 5'd0);
            if (any_grant) begin
                write_address_reg <= grant_address;
                write_data_reg    <= grant_data;
            end
        end
    end

    assign bus.aluReady      = alu_grant;
    assign bus.memReady      = mem_grant;
    assign bus.registerWrite = register_write_reg;
    assign bus.writeAddress  = write_address_reg;
    assign bus.writeData     = write_data_reg;

    // Hazard: a source operand or the new destination is still owed.
    assign bus.stall = pending_reg[bus.rsAddress] || pending_reg[bus.rtAddress] ||
                       (bus.issueValid && pending_reg[bus.issueAddress]);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios followed by
// random traffic, all compared against a behavioural model of the arbiter.
module tb_regfile_write_arbiter;

    localparam int MAXS = 4;

    logic clk;
    logic rst;
    regfile_write_arbiter_if bus ();

    regfile_write_arbiter #(.MAX_STARVE(MAXS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int          m_starve;
    bit          m_pend [32];
    bit          m_we;
    bit          m_bus_known;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit owed(input logic [4:0] a);
        return (a != 5'd0) && m_pend[a];
    endfunction

    task automatic model_reset();
        m_starve = 0;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_we = 1'b0;
        m_addr = 5'd0;
        m_data = 32'd0;
        m_bus_known = 1'b1;
    endtask

    task automatic set_idle();
        bus.aluValid = 0; bus.aluAddress = 0; bus.aluData = 0;
        bus.memValid = 0; bus.memAddress = 0; bus.memData = 0;
        bus.issueValid = 0; bus.issueAddress = 0;
        bus.rsAddress = 0; bus.rtAddress = 0;
    endtask

    task automatic set_random(input int span);
        bus.aluValid = 1'($urandom_range(1));
        bus.aluAddress = 5'($urandom_range(span));
        bus.aluData = $urandom;
        bus.memValid = 1'($urandom_range(1));
        bus.memAddress = 5'($urandom_range(span));
        bus.memData = $urandom;
        bus.issueValid = ($urandom_range(3) == 0);
        bus.issueAddress = 5'($urandom_range(span));
        bus.rsAddress = 5'($urandom_range(span));
        bus.rtAddress = 5'($urandom_range(span));
    endtask

    // One clock cycle with the currently driven inputs: check the combinational
    // outputs, advance the model across the edge, then check the write port.
    task automatic cycle(input string tag);
        int winner;  // 0 none, 1 alu, 2 mem
        bit e_stall;
        logic [4:0]  g_addr;
        logic [31:0] g_data;
        #1;
        if (!rst) model_reset();
        winner = 0;
        if (rst) begin
            if (bus.aluValid && bus.memValid) winner = (m_starve == MAXS) ? 2 : 1;
            else if (bus.aluValid) winner = 1;
            else if (bus.memValid) winner = 2;
        end
        e_stall = owed(bus.rsAddress) || owed(bus.rtAddress) ||
                  (bus.issueValid && owed(bus.issueAddress));
        chk({tag, ".aluReady"}, 32'(bus.aluReady), 32'(winner == 1));
        chk({tag, ".memReady"}, 32'(bus.memReady), 32'(winner == 2));
        chk({tag, ".stall"}, 32'(bus.stall), 32'(e_stall));
        if (!rst) chk({tag, ".rstWrite"}, 32'(bus.registerWrite), 32'd0);
        @(posedge clk);
        #1;
        if (rst) begin
            if (winner == 2) m_pend[bus.memAddress] = 1'b0;
            if (bus.issueValid && bus.issueAddress != 5'd0) m_pend[bus.issueAddress] = 1'b1;
            if (bus.aluValid && bus.memValid && winner == 1)
                m_starve = (m_starve + 1 > MAXS) ? MAXS : m_starve + 1;
            else
                m_starve = 0;
            m_we = 1'b0;
            if (winner != 0) begin
                g_addr = (winner == 1) ? bus.aluAddress : bus.memAddress;
                g_data = (winner == 1) ? bus.aluData : bus.memData;
                if (g_addr != 5'd0) begin
                    m_we = 1'b1; m_addr = g_addr; m_data = g_data; m_bus_known = 1'b1;
                end else begin
                    m_bus_known = 1'b0;
                end
            end
        end
        chk({tag, ".registerWrite"}, 32'(bus.registerWrite), 32'(m_we));
        if (m_bus_known) begin
            chk({tag, ".writeAddress"}, 32'(bus.writeAddress), 32'(m_addr));
            chk({tag, ".writeData"}, bus.writeData, m_data);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        set_idle();
        model_reset();
        #1;

        // Reset held with random inputs: every output stays 0
        for (int i = 0; i < 4; i++) begin
            set_random(31);
            cycle("reset_hold");
            chk("reset_hold.writeAddress", 32'(bus.writeAddress), 32'd0);
            chk("reset_hold.writeData", bus.writeData, 32'd0);
        end

        // First ALU write after release
        rst = 1'b1;
        set_idle();
        bus.aluValid = 1; bus.aluAddress = 5'd5; bus.aluData = 32'hDEADBEEF;
        cycle("first_write");
        chk("first_write.writeAddress", 32'(bus.writeAddress), 32'd5);
        chk("first_write.writeData", bus.writeData, 32'hDEADBEEF);
        set_idle();
        cycle("idle");

        // Starvation: both valid every cycle -> ALU x4 then mem, repeating
        for (int i = 0; i < 10; i++) begin
            bus.aluValid = 1; bus.aluAddress = 5'(1 + i); bus.aluData = 32'(32'hA000 + i);
            bus.memValid = 1; bus.memAddress = 5'(20 + i % 5); bus.memData = 32'(32'hB000 + i);
            #1;
            chk("starve.pattern", 32'(bus.memReady), 32'(i % 5 == 4));
            cycle("starve");
        end
        set_idle();
        cycle("idle");

        // Scoreboard: issue r7, RAW stall until the mem write to r7
        bus.issueValid = 1; bus.issueAddress = 5'd7;
        cycle("issue7");
        set_idle();
        bus.rsAddress = 5'd7;
        #1;
        chk("sb.stall_rs7", 32'(bus.stall), 32'd1);
        cycle("sb_wait");
        // mem write to r0 is dropped and leaves r7 owed
        bus.memValid = 1; bus.memAddress = 5'd0; bus.memData = 32'h1234;
        cycle("addr0");
        chk("addr0.dropped", 32'(bus.registerWrite), 32'd0);
        bus.memValid = 0;
        #1;
        chk("addr0.still_pending", 32'(bus.stall), 32'd1);
        bus.memValid = 1; bus.memAddress = 5'd7; bus.memData = 32'h7777;
        cycle("sb_grant7");
        bus.memValid = 0;
        #1;
        chk("sb.stall_cleared", 32'(bus.stall), 32'd0);
        bus.rsAddress = 5'd0; bus.rtAddress = 5'd0;
        cycle("sb_rt0");

        // Simultaneous set/clear on r9: set wins
        bus.issueValid = 1; bus.issueAddress = 5'd9;
        cycle("issue9");
        bus.memValid = 1; bus.memAddress = 5'd9; bus.memData = 32'h9999;
        cycle("setclr9");
        set_idle();
        bus.rsAddress = 5'd9;
        #1;
        chk("setclr.stall_rs9", 32'(bus.stall), 32'd1);
        cycle("setclr_after");
        bus.memValid = 1; bus.memAddress = 5'd9; bus.memData = 32'h9A9A;
        cycle("clear9");
        set_idle();

        // Reset mid-operation with r3/r4 owed and mem result held
        bus.issueValid = 1; bus.issueAddress = 5'd3;
        bus.aluValid = 1; bus.aluAddress = 5'd11; bus.aluData = 32'h1111;
        cycle("issue3");
        bus.issueAddress = 5'd4;
        cycle("issue4");
        set_idle();
        bus.memValid = 1; bus.memAddress = 5'd12; bus.memData = 32'hC0FFEE;
        bus.rsAddress = 5'd3; bus.rtAddress = 5'd4;
        rst = 1'b0;
        cycle("rst_mid");
        chk("rst_mid.stall", 32'(bus.stall), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_mid.reaccept", 32'(bus.memReady), 32'd1);
        cycle("rst_release");
        set_idle();
        cycle("idle");

        // Random traffic over a narrow address range to force collisions
        for (int i = 0; i < 400; i++) begin
            set_random(7);
            cycle("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
